// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, issue/scoreboard handshake and writeback.
// The master side is the pipeline; the slave side is the register file.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   i_rs1_addr;
   logic [AW-1:0]   i_rs2_addr;
   logic [XLEN-1:0] o_rs1_data;
   logic [XLEN-1:0] o_rs2_data;
   logic            o_rs1_busy;
   logic            o_rs2_busy;
   logic            i_issue_en;
   logic [AW-1:0]   i_issue_rd;
   logic            o_issue_ready;
   logic            i_wr_en;
   logic [AW-1:0]   i_wr_addr;
   logic [XLEN-1:0] i_wr_data;
   logic            i_flush;
   logic            o_wb_err;

   modport master (
      output i_rs1_addr, i_rs2_addr, i_issue_en, i_issue_rd,
      output i_wr_en, i_wr_addr, i_wr_data, i_flush,
      input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy,
      input  o_issue_ready, o_wb_err
   );

   modport slave (
      input  i_rs1_addr, i_rs2_addr, i_issue_en, i_issue_rd,
      input  i_wr_en, i_wr_addr, i_wr_data, i_flush,
      output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy,
      output o_issue_ready, o_wb_err
   );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-write scoreboard,
// two combinational read ports, one write port and optional bypass.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = 5,
   parameter int PEND_W = 2,
   parameter int BYPASS = 1
) (
   input logic         clk,
   input logic         i_reset,
   regfile_sb_if.slave rf
);
   localparam logic [PEND_W-1:0] PMAX = '1;

   logic [XLEN-1:0]   regs [NREGS];
   logic [PEND_W-1:0] pend [NREGS];
   logic              wb_err;
   logic              issue_ready;
   logic [NREGS-1:0]  inc;
   logic [NREGS-1:0]  dec;

   function automatic logic [XLEN-1:0] rd_data(
      input logic [AW-1:0]   a,
      input logic [XLEN-1:0] stored,
      input logic            wen,
      input logic [AW-1:0]   waddr,
      input logic [XLEN-1:0] wdata
   );
      if (a == '0)
         return '0;
      if (BYPASS != 0 && wen && waddr == a)
         return wdata;
      return stored;
   endfunction

   // A last outstanding write satisfied by forwarded data is not a hazard.
   function automatic logic rd_busy(
      input logic [AW-1:0]     a,
      input logic [PEND_W-1:0] p,
      input logic              wen,
      input logic [AW-1:0]     waddr
   );
      logic b;
      b = (a != '0) && (p != '0);
      if (BYPASS != 0 && wen && waddr == a && p == PEND_W'(1))
         b = 1'b0;
      return b;
   endfunction

   assign issue_ready = (rf.i_issue_rd == '0) ||
                        (pend[rf.i_issue_rd] != PMAX);

   assign rf.o_issue_ready = issue_ready;
   assign rf.o_wb_err      = wb_err;

   assign rf.o_rs1_data = rd_data(rf.i_rs1_addr, regs[rf.i_rs1_addr],
                                  rf.i_wr_en, rf.i_wr_addr, rf.i_wr_data);
   assign rf.o_rs2_data = rd_data(rf.i_rs2_addr, regs[rf.i_rs2_addr],
                                  rf.i_wr_en, rf.i_wr_addr, rf.i_wr_data);
   assign rf.o_rs1_busy = rd_busy(rf.i_rs1_addr, pend[rf.i_rs1_addr],
                                  rf.i_wr_en, rf.i_wr_addr);
   assign rf.o_rs2_busy = rd_busy(rf.i_rs2_addr, pend[rf.i_rs2_addr],
                                  rf.i_wr_en, rf.i_wr_addr);

   always_comb begin
      inc = '0;
      dec = '0;
      if (rf.i_issue_en && issue_ready && rf.i_issue_rd != '0)
         inc[rf.i_issue_rd] = 1'b1;
      if (rf.i_wr_en && rf.i_wr_addr != '0 && pend[rf.i_wr_addr] != '0)
         dec[rf.i_wr_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
         wb_err <= 1'b0;
      end else begin
         if (rf.i_wr_en && rf.i_wr_addr != '0)
            regs[rf.i_wr_addr] <= rf.i_wr_data;
         for (int r = 1; r < NREGS; r++) begin
            if (rf.i_flush)
               pend[r] <= '0;
            else if (inc[r] && !dec[r])
               pend[r] <= pend[r] + 1'b1;
            else if (dec[r] && !inc[r])
               pend[r] <= pend[r] - 1'b1;
         end
         // Writeback with nothing outstanding is a pipeline bug; keep it.
         if (!rf.i_flush && rf.i_wr_en && rf.i_wr_addr != '0 &&
             pend[rf.i_wr_addr] == '0)
            wb_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a
// randomized run against an array-based scoreboard model.
module tb_regfile_sb;
   logic clk = 1'b0;
   logic i_reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   regfile_sb_if #(.XLEN(32), .AW(5)) bus ();

   regfile_sb #(
      .XLEN(32), .NREGS(32), .AW(5), .PEND_W(2), .BYPASS(1)
   ) dut (
      .clk(clk),
      .i_reset(i_reset),
      .rf(bus)
   );

   always #5 clk = ~clk;

   logic [31:0] m_regs [32];
   int          m_p [32];
   bit          m_err;

   function automatic logic [31:0] m_read(input int a);
      if (a == 0) return 32'h0;
      if (bus.i_wr_en && int'(bus.i_wr_addr) == a) return bus.i_wr_data;
      return m_regs[a];
   endfunction

   function automatic bit m_busy(input int a);
      if (a == 0 || m_p[a] == 0) return 1'b0;
      if (bus.i_wr_en && int'(bus.i_wr_addr) == a && m_p[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_ready(input int rd);
      return rd == 0 || m_p[rd] < 3;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 32'h0;
         m_p[r] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic idle();
      bus.i_rs1_addr = '0; bus.i_rs2_addr = '0;
      bus.i_issue_en = 1'b0; bus.i_issue_rd = '0;
      bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      bus.i_flush = 1'b0;
   endtask

   // Advance one clock, updating the model from the inputs now applied.
   task automatic tick();
      int rd = int'(bus.i_issue_rd);
      int wa = int'(bus.i_wr_addr);
      int np [32];
      for (int r = 0; r < 32; r++) np[r] = m_p[r];
      if (bus.i_flush) begin
         for (int r = 0; r < 32; r++) np[r] = 0;
      end else begin
         if (bus.i_issue_en && rd != 0 && m_ready(rd)) np[rd]++;
         if (bus.i_wr_en && wa != 0) begin
            if (m_p[wa] == 0) m_err = 1'b1;
            else np[wa]--;
         end
      end
      if (bus.i_wr_en && wa != 0) m_regs[wa] = bus.i_wr_data;
      for (int r = 0; r < 32; r++) m_p[r] = np[r];
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      i_reset = 1'b1;
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      m_clear();
      #1;
   endtask

   task automatic test_reset();
      logic bad;
      do_reset();
      bad = 1'b0;
      for (int a = 0; a < 32; a++) begin
         bus.i_rs1_addr = 5'(a);
         bus.i_rs2_addr = 5'(31 - a);
         bus.i_issue_rd = 5'(a);
         #1;
         if (bus.o_rs1_data !== 32'h0 || bus.o_rs2_data !== 32'h0 ||
             bus.o_rs1_busy !== 1'b0 || bus.o_rs2_busy !== 1'b0 ||
             bus.o_issue_ready !== 1'b1)
            bad = 1'b1;
      end
      n_tests++;
      if (bad !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_regs: nonzero read/busy or ready low, expected clean state");
      end
      n_tests++;
      if (bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b expected 0", bus.o_wb_err);
      end
      idle();
   endtask

   task automatic test_bypass();
      do_reset();
      bus.i_issue_en = 1'b1; bus.i_issue_rd = 5'd5;
      tick();
      idle();
      bus.i_rs1_addr = 5'd5;
      #2;
      n_tests++;
      if (bus.o_rs1_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL byp_busy: got %b expected 1", bus.o_rs1_busy);
      end
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd5; bus.i_wr_data = 32'hDEADBEEF;
      #2;
      n_tests++;
      if (bus.o_rs1_data !== 32'hDEADBEEF || bus.o_rs1_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL byp_fwd: got %h/%b expected deadbeef/0",
                  bus.o_rs1_data, bus.o_rs1_busy);
      end
      tick();
      bus.i_wr_en = 1'b0;
      #2;
      n_tests++;
      if (bus.o_rs1_data !== 32'hDEADBEEF || bus.o_rs1_busy !== 1'b0 ||
          bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL byp_stored: got %h/%b/%b expected deadbeef/0/0",
                  bus.o_rs1_data, bus.o_rs1_busy, bus.o_wb_err);
      end
      idle();
   endtask

   task automatic test_saturate();
      logic [2:0] exp_busy;
      do_reset();
      bus.i_issue_en = 1'b1; bus.i_issue_rd = 5'd7;
      tick(); tick(); tick();
      #1;
      n_tests++;
      if (bus.o_issue_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_ready: got %b expected 0", bus.o_issue_ready);
      end
      tick();
      idle();
      bus.i_rs1_addr = 5'd7;
      exp_busy = 3'b011;
      for (int i = 0; i < 3; i++) begin
         bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd7; bus.i_wr_data = 32'(i + 100);
         #1;
         n_tests++;
         if (bus.o_rs1_busy !== exp_busy[i]) begin
            n_fail++;
            $display("FAIL sat_busy%0d: got %b expected %b",
                     i, bus.o_rs1_busy, exp_busy[i]);
         end
         tick();
      end
      bus.i_wr_en = 1'b0;
      #1;
      n_tests++;
      if (bus.o_rs1_busy !== 1'b0 || bus.o_wb_err !== 1'b0 ||
          bus.o_issue_ready !== 1'b1 || bus.o_rs1_data !== 32'd102) begin
         n_fail++;
         $display("FAIL sat_drain: got busy %b err %b rdy %b data %h",
                  bus.o_rs1_busy, bus.o_wb_err, bus.o_issue_ready, bus.o_rs1_data);
      end
      idle();
   endtask

   task automatic test_x0_err();
      do_reset();
      bus.i_issue_en = 1'b1; bus.i_issue_rd = 5'd0;
      #1;
      n_tests++;
      if (bus.o_issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL x0_ready: got %b expected 1", bus.o_issue_ready);
      end
      tick();
      idle();
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd0; bus.i_wr_data = 32'h1234;
      #1;
      n_tests++;
      if (bus.o_rs1_data !== 32'h0 || bus.o_rs1_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_fwd: got %h/%b expected 0/0",
                  bus.o_rs1_data, bus.o_rs1_busy);
      end
      tick();
      bus.i_wr_en = 1'b0;
      #1;
      n_tests++;
      if (bus.o_rs1_data !== 32'h0 || bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_write: got %h/%b expected 0/0",
                  bus.o_rs1_data, bus.o_wb_err);
      end
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd9; bus.i_wr_data = 32'hCAFE0009;
      tick();
      bus.i_wr_en = 1'b0;
      tick();
      bus.i_rs2_addr = 5'd9;
      #1;
      n_tests++;
      if (bus.o_wb_err !== 1'b1 || bus.o_rs2_data !== 32'hCAFE0009) begin
         n_fail++;
         $display("FAIL wb_err: got %b/%h expected 1/cafe0009",
                  bus.o_wb_err, bus.o_rs2_data);
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      bus.i_issue_en = 1'b1; bus.i_issue_rd = 5'd3;
      tick();
      bus.i_issue_rd = 5'd4;
      tick();
      bus.i_issue_rd = 5'd6;
      bus.i_flush = 1'b1;
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd3; bus.i_wr_data = 32'h55;
      tick();
      idle();
      bus.i_rs1_addr = 5'd3; bus.i_rs2_addr = 5'd4;
      #1;
      n_tests++;
      if (bus.o_rs1_busy !== 1'b0 || bus.o_rs2_busy !== 1'b0 ||
          bus.o_rs1_data !== 32'h55 || bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: got busy %b%b data %h err %b expected 00/55/0",
                  bus.o_rs1_busy, bus.o_rs2_busy, bus.o_rs1_data, bus.o_wb_err);
      end
      bus.i_rs1_addr = 5'd6;
      #1;
      n_tests++;
      if (bus.o_rs1_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_issue: got %b expected 0", bus.o_rs1_busy);
      end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd6; bus.i_wr_data = 32'hAA;
      tick();
      idle();
      bus.i_issue_en = 1'b1; bus.i_issue_rd = 5'd6;
      tick(); tick();
      idle();
      bus.i_rs1_addr = 5'd6;
      #1;
      n_tests++;
      if (bus.o_rs1_data !== 32'hAA || bus.o_rs1_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre: got %h/%b expected aa/1",
                  bus.o_rs1_data, bus.o_rs1_busy);
      end
      #1;
      i_reset = 1'b1;
      #1;
      n_tests++;
      if (bus.o_rs1_data !== 32'h0 || bus.o_rs1_busy !== 1'b0 ||
          bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL areset: got %h/%b/%b expected 0/0/0",
                  bus.o_rs1_data, bus.o_rs1_busy, bus.o_wb_err);
      end
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      m_clear();
      idle();
   endtask

   task automatic test_random();
      int a1, a2, rd;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus.i_rs1_addr = 5'($urandom_range(0, 4));
         bus.i_rs2_addr = 5'($urandom_range(0, 4));
         bus.i_issue_en = 1'($urandom_range(0, 1));
         bus.i_issue_rd = 5'($urandom_range(0, 4));
         bus.i_wr_en = ($urandom_range(0, 2) == 0);
         bus.i_wr_addr = 5'($urandom_range(0, 4));
         bus.i_wr_data = $urandom;
         bus.i_flush = ($urandom_range(0, 24) == 0);
         if (c == 200) begin
            m_clear();
            i_reset = 1'b1;
            #1;
            i_reset = 1'b0;
         end
         #1;
         a1 = int'(bus.i_rs1_addr);
         a2 = int'(bus.i_rs2_addr);
         rd = int'(bus.i_issue_rd);
         n_tests++;
         if (bus.o_rs1_data !== m_read(a1) || bus.o_rs2_data !== m_read(a2)) begin
            n_fail++;
            $display("FAIL rnd_data c%0d: got %h %h expected %h %h",
                     c, bus.o_rs1_data, bus.o_rs2_data, m_read(a1), m_read(a2));
         end
         n_tests++;
         if (bus.o_rs1_busy !== m_busy(a1) || bus.o_rs2_busy !== m_busy(a2)) begin
            n_fail++;
            $display("FAIL rnd_busy c%0d: got %b%b expected %b%b",
                     c, bus.o_rs1_busy, bus.o_rs2_busy, m_busy(a1), m_busy(a2));
         end
         n_tests++;
         if (bus.o_issue_ready !== m_ready(rd) || bus.o_wb_err !== m_err) begin
            n_fail++;
            $display("FAIL rnd_ctl c%0d: got rdy %b err %b expected %b %b",
                     c, bus.o_issue_ready, bus.o_wb_err, m_ready(rd), m_err);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      m_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_bypass();
      test_saturate();
      test_x0_err();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined core, with a per-register pending-write scoreboard. Provides two combinational read ports and one write port, with an optional writeback-to-read bypass and a hard-wired zero register x0. Decode uses the busy outputs to stall on RAW hazards. Writeback and flush retire outstanding writes.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
AW, 5, address width, must equal log2(NREGS)
PEND_W, 2, width of each pending-write counter; max outstanding writes per register = 2^PEND_W-1
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
i_reset  in  1  asynchronous, active-high reset
i_rs1_addr  in  AW  read port 1 address
i_rs2_addr  in  AW  read port 2 address
o_rs1_data  out  XLEN  read port 1 data (combinational)
o_rs2_data  out  XLEN  read port 2 data (combinational)
o_rs1_busy  out  1  rs1 has an outstanding write not satisfied this cycle
o_rs2_busy  out  1  rs2 has an outstanding write not satisfied this cycle
i_issue_en  in  1  instruction with destination i_issue_rd issues this cycle
i_issue_rd  in  AW  destination register of the issuing instruction
o_issue_ready  out  1  issue will be accepted (pending[i_issue_rd] not saturated)
i_wr_en  in  1  writeback valid
i_wr_addr  in  AW  writeback destination
i_wr_data  in  XLEN  writeback data
i_flush  in  1  pipeline flush: discard all outstanding writes
o_wb_err  out  1  sticky: writeback arrived to a register with pending==0

Behaviour:
- Reset (async, immediate): all registers = 0, all pending counters = 0, o_wb_err = 0. Outputs follow: data 0, busy 0, o_issue_ready 1.
- x0: reads always 0. Writes are discarded. The pending counter stays 0. Issue to x0 is always ready and has no effect. Writeback to x0 never sets o_wb_err.
- Write: on clk edge with i_wr_en and i_wr_addr!=0, regs[i_wr_addr] <= i_wr_data. Data is always written, including during flush.
- Read: o_rsN_data = 0 if addr==0. Otherwise, if BYPASS and i_wr_en and i_wr_addr==addr, it is i_wr_data. Otherwise it is regs[addr]. Read latency is 0 cycles.
- Pending counter p[r], r!=0, per clock edge:
  - i_flush=1: p[r] <= 0 for all r. The same-cycle issue is dropped and no o_wb_err update occurs.
  - inc = i_issue_en & o_issue_ready & (i_issue_rd==r).
  - dec = i_wr_en & (i_wr_addr==r) & (p[r]!=0).
  - inc&dec: p unchanged. inc only: p+1. dec only: p-1.
- o_issue_ready = (i_issue_rd==0) | (p[i_issue_rd] != 2^PEND_W-1). An issue with ready=0 is ignored, and the issuer must hold the request.
- o_rsN_busy = (addrN!=0) & (p[addrN]!=0), with one exception when BYPASS=1: busy=0 if i_wr_en, i_wr_addr==addrN and p[addrN]==1. In that case the forwarded data satisfies the read. With BYPASS=0 there is no exception, and the register is seen free from the next cycle.
- o_wb_err: set on an edge where i_wr_en, i_wr_addr!=0, p[i_wr_addr]==0 and i_flush==0. Cleared only by reset. The data is still written.
- Flush and writeback in the same cycle: data written, counters zeroed.
- Issue and writeback to the same register in the same cycle with p==0: writeback flags o_wb_err, issue increments p to 1.
- Reset mid-operation clears all state regardless of in-flight issue or writeback.

Test Plan:
- Reset, then read all 32 registers on both ports -> all 0, busy 0, o_issue_ready 1, o_wb_err 0.
- Issue rd=5; next cycle rs1=5 -> busy 1. Writeback x5=0xDEADBEEF with rs1=5 in the same cycle, BYPASS=1 -> o_rs1_data=0xDEADBEEF, busy 0. Next cycle -> regs[5]=0xDEADBEEF, busy 0.
- Issue rd=7 three times (PEND_W=2) -> p=3, o_issue_ready=0 for rd=7. The 4th issue is ignored. Three writebacks -> busy clears only after the third.
- Issue rd=0, then write x0=0x1234 -> rs1=0 reads 0, busy 0, o_wb_err 0. Writeback x9 with p[9]=0 -> o_wb_err=1 and it stays 1; regs[9] is updated.
- Issue rd=3, rd=4, then assert i_flush together with writeback x3=0x55 -> p all 0, busy 0, regs[3]=0x55, o_wb_err 0. The issue asserted in the flush cycle is dropped.
- Assert i_reset asynchronously mid-cycle with p[6]=2 and regs[6]=0xAA -> immediately data 0 and busy 0, before the next clk edge.
